decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered RV32I/RV64I decode stage sitting between the IF/ID boundary and the ID/EX pipeline register. It splits the instruction into raw fields and classifies its format. It generates the sign-extended immediate and flags register usage and illegal encodings. All outputs are held in a single output register with a valid/ready handshake, stall (backpressure) and flush.

Parameters:
XLEN, 32, datapath width for pc and imm; legal values 32 or 64.
ENABLE_SYSTEM, 1, 1: opcodes 0001111 (FENCE) and 1110011 (SYSTEM) are legal; 0: they are flagged illegal.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
in_instr  input  32  instruction word
in_pc  input  XLEN  pc of in_instr
flush  input  1  kill held and incoming instruction
out_valid  output  1  decoded bundle valid
out_ready  input  1  downstream accepts bundle
out_pc  output  XLEN  registered pc
opcode  output  7  instr[6:0]
rd  output  5  instr[11:7]
funct3  output  3  instr[14:12]
rs1  output  5  instr[19:15]
rs2  output  5  instr[24:20]
funct7  output  7  instr[31:25]
fmt  output  3  format: R=0 I=1 S=2 B=3 U=4 J=5 NONE=7
imm  output  XLEN  sign-extended immediate
uses_rs1  output  1  rs1 is a true source
uses_rs2  output  1  rs2 is a true source
writes_rd  output  1  instruction writes rd and rd != 0
illegal  output  1  unrecognised encoding

Behaviour:
- Reset (rst=1 at edge): out_valid=0; all other outputs 0, including out_pc, fields, imm, fmt=0 and flags. Reset takes priority over flush and load.
- in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
- Load: when in_valid && in_ready && !flush, all outputs are registered from decode of in_instr/in_pc and out_valid becomes 1. Latency is 1 cycle.
- Drain: when out_valid && out_ready && !(in_valid && in_ready && !flush), out_valid becomes 0. Data registers may hold stale values.
- Stall: while out_valid && !out_ready, every output holds bit-stable and in_instr is not sampled.
- Simultaneous accept and drain (out_valid, out_ready, in_valid all 1): the new bundle replaces the old one with no bubble.
- Flush: out_valid becomes 0 next cycle. The incoming instruction is discarded even if in_valid && in_ready. in_ready follows its normal equation during flush.
- Field outputs are always raw bit slices, regardless of format.
- Format and flags, by opcode:
  - 0110011 (OP): R; rs1, rs2 and rd used.
  - 0010011 (OP-IMM), 0000011 (LOAD) and 1100111 (JALR): I; rs1 and rd used.
  - 0100011 (STORE): S; rs1 and rs2 used.
  - 1100011 (BRANCH): B; rs1 and rs2 used.
  - 0110111 (LUI) and 0010111 (AUIPC): U; rd used.
  - 1101111 (JAL): J; rd used.
  - 0001111 and 1110011 with ENABLE_SYSTEM=1: I; rs1 and rd used.
- writes_rd = (format uses rd) && rd != 0.
- XLEN=64 adds 0011011 (OP-IMM-32) as I and 0111011 (OP-32) as R. With XLEN=32 these two opcodes are illegal.
- Immediates (sign bit is instr[31], extended to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and NONE: imm=0.
- Illegal: any other opcode, or instr[1:0] != 2'b11, sets illegal=1, fmt=7, imm=0 and all three flags 0. The bundle still passes with out_valid=1 so the exception can be taken downstream.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=1.
- Accept 0xFFF10093 at pc 0x100, out_ready=1 -> next cycle: out_valid=1, opcode=0x13, rd=1, rs1=2, fmt=1, imm=0xFFFFFFFF, uses_rs1=1, uses_rs2=0, writes_rd=1, out_pc=0x100.
- Format sweep, one per cycle:
  - 0x00512423 -> fmt=2, imm=8, rs2=5, writes_rd=0.
  - 0xFE000EE3 -> fmt=3, imm=0xFFFFFFFC.
  - 0x123451B7 -> fmt=4, imm=0x12345000, rd=3.
  - 0x001000EF -> fmt=5, imm=0x800.
  - 0x00000013 -> writes_rd=0.
- Backpressure: load bundle A, hold out_ready=0 for 3 cycles with B offered -> outputs stay A and in_ready=0. Raise out_ready -> B appears the next cycle with no gap and no duplicate of A.
- Flush: flush=1 with bundle held and in_valid=1 -> next cycle out_valid=0 and the incoming word is never seen. Flush during stall behaves the same.
- Illegal and params:
  - 0x00000000 -> illegal=1, fmt=7, imm=0, out_valid=1.
  - 0x0000000F with ENABLE_SYSTEM=0 -> illegal=1.
  - XLEN=64: 0xFFF1009B -> fmt=1, imm=0xFFFFFFFFFFFFFFFF.
  - XLEN=32: 0xFFF1009B -> illegal=1.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: splits the instruction into fields, classifies its format,
// builds the sign-extended immediate and holds the result in one valid/ready output register.
module decode_stage #(
   parameter int XLEN          = 32,
   parameter bit ENABLE_SYSTEM = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [6:0]      funct7,
   output logic [2:0]      fmt,
   output logic [XLEN-1:0] imm,
   output logic            uses_rs1,
   output logic            uses_rs2,
   output logic            writes_rd,
   output logic            illegal
);

   localparam logic [2:0] FMT_R    = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_NONE = 3'd7;
   localparam bit         IS_RV64  = (XLEN == 64);

   logic [2:0]        fmt_next;
   logic [XLEN-1:0]   imm_next;
   logic              uses_rs1_next, uses_rs2_next, uses_rd_next, illegal_next;
   logic              load;

   logic signed [11:0] imm_i;
   logic signed [11:0] imm_s;
   logic signed [12:0] imm_b;
   logic signed [31:0] imm_u;
   logic signed [20:0] imm_j;

   logic              valid_reg;
   logic [XLEN-1:0]   pc_reg;
   logic [31:0]       instr_reg;
   logic [2:0]        fmt_reg;
   logic [XLEN-1:0]   imm_reg;
   logic              uses_rs1_reg, uses_rs2_reg, writes_rd_reg, illegal_reg;

   assign imm_i = in_instr[31:20];
   assign imm_s = {in_instr[31:25], in_instr[11:7]};
   assign imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   always_comb begin
      fmt_next      = FMT_NONE;
      uses_rs1_next = 1'b0;
      uses_rs2_next = 1'b0;
      uses_rd_next  = 1'b0;
      illegal_next  = 1'b0;
      if (in_instr[1:0] != 2'b11) begin
         illegal_next = 1'b1;
      end else begin
         case (in_instr[6:0])
            7'b0110011: begin
               fmt_next = FMT_R; uses_rs1_next = 1'b1; uses_rs2_next = 1'b1; uses_rd_next = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
               fmt_next = FMT_I; uses_rs1_next = 1'b1; uses_rd_next = 1'b1;
            end
            7'b0100011: begin
               fmt_next = FMT_S; uses_rs1_next = 1'b1; uses_rs2_next = 1'b1;
            end
            7'b1100011: begin
               fmt_next = FMT_B; uses_rs1_next = 1'b1; uses_rs2_next = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
               fmt_next = FMT_U; uses_rd_next = 1'b1;
            end
            7'b1101111: begin
               fmt_next = FMT_J; uses_rd_next = 1'b1;
            end
            7'b0001111, 7'b1110011: begin
               if (ENABLE_SYSTEM) begin
                  fmt_next = FMT_I; uses_rs1_next = 1'b1; uses_rd_next = 1'b1;
               end else begin
                  illegal_next = 1'b1;
               end
            end
            7'b0011011: begin
               if (IS_RV64) begin
                  fmt_next = FMT_I; uses_rs1_next = 1'b1; uses_rd_next = 1'b1;
               end else begin
                  illegal_next = 1'b1;
               end
            end
            7'b0111011: begin
               if (IS_RV64) begin
                  fmt_next = FMT_R; uses_rs1_next = 1'b1; uses_rs2_next = 1'b1; uses_rd_next = 1'b1;
               end else begin
                  illegal_next = 1'b1;
               end
            end
            default: illegal_next = 1'b1;
         endcase
      end
   end

   // R and NONE formats carry no immediate; fmt_next is already NONE for illegal words
   always_comb begin
      imm_next = '0;
      case (fmt_next)
         FMT_I:   imm_next = XLEN'(imm_i);
         FMT_S:   imm_next = XLEN'(imm_s);
         FMT_B:   imm_next = XLEN'(imm_b);
         FMT_U:   imm_next = XLEN'(imm_u);
         FMT_J:   imm_next = XLEN'(imm_j);
         default: imm_next = '0;
      endcase
   end

   assign in_ready = !valid_reg || out_ready;
   assign load     = in_valid && in_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg     <= 1'b0;
         pc_reg        <= '0;
         instr_reg     <= '0;
         fmt_reg       <= '0;
         imm_reg       <= '0;
         uses_rs1_reg  <= 1'b0;
         uses_rs2_reg  <= 1'b0;
         writes_rd_reg <= 1'b0;
         illegal_reg   <= 1'b0;
      end else begin
         if (load) begin
            pc_reg        <= in_pc;
            instr_reg     <= in_instr;
            fmt_reg       <= fmt_next;
            imm_reg       <= imm_next;
            uses_rs1_reg  <= uses_rs1_next;
            uses_rs2_reg  <= uses_rs2_next;
            writes_rd_reg <= uses_rd_next && (in_instr[11:7] != 5'd0);
            illegal_reg   <= illegal_next;
         end
         if (flush)          valid_reg <= 1'b0;
         else if (load)      valid_reg <= 1'b1;
         else if (out_ready) valid_reg <= 1'b0;
      end
   end

   assign out_valid = valid_reg;
   assign out_pc    = pc_reg;
   assign opcode    = instr_reg[6:0];
   assign rd        = instr_reg[11:7];
   assign funct3    = instr_reg[14:12];
   assign rs1       = instr_reg[19:15];
   assign rs2       = instr_reg[24:20];
   assign funct7    = instr_reg[31:25];
   assign fmt       = fmt_reg;
   assign imm       = imm_reg;
   assign uses_rs1  = uses_rs1_reg;
   assign uses_rs2  = uses_rs2_reg;
   assign writes_rd = writes_rd_reg;
   assign illegal   = illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (RV32 with system ops, RV64 without) driven together,
// checked against a directed table, hand sequences and a cycle model on random traffic.
module tb_decode_stage;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  funct7;
      logic [2:0]  fmt;
      logic [63:0] imm;
      logic        u1, u2, wr, ill;
   } bundle_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  fmt;
      logic [31:0] imm;
      logic [4:0]  rd, rs1, rs2;
      logic        u1, u2, wr, ill;
      logic [2:0]  fmt64;
      logic [63:0] imm64;
      logic        ill64;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, flush, out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        r32, v32, u1_32, u2_32, wr32, il32;
   logic [31:0] pc32, imm32;
   logic [6:0]  op32, f7_32;
   logic [4:0]  rd32, rs1_32, rs2_32;
   logic [2:0]  f3_32, fmt32;

   logic        r64, v64, u1_64, u2_64, wr64, il64;
   logic [63:0] pc64, imm64;
   logic [6:0]  op64, f7_64;
   logic [4:0]  rd64, rs1_64, rs2_64;
   logic [2:0]  f3_64, fmt64;

   decode_stage #(.XLEN(32), .ENABLE_SYSTEM(1'b1)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr),
      .in_pc(in_pc[31:0]), .flush(flush), .out_valid(v32), .out_ready(out_ready),
      .out_pc(pc32), .opcode(op32), .rd(rd32), .funct3(f3_32), .rs1(rs1_32), .rs2(rs2_32),
      .funct7(f7_32), .fmt(fmt32), .imm(imm32), .uses_rs1(u1_32), .uses_rs2(u2_32),
      .writes_rd(wr32), .illegal(il32));

   decode_stage #(.XLEN(64), .ENABLE_SYSTEM(1'b0)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr),
      .in_pc(in_pc), .flush(flush), .out_valid(v64), .out_ready(out_ready),
      .out_pc(pc64), .opcode(op64), .rd(rd64), .funct3(f3_64), .rs1(rs1_64), .rs2(rs2_64),
      .funct7(f7_64), .fmt(fmt64), .imm(imm64), .uses_rs1(u1_64), .uses_rs2(u2_64),
      .writes_rd(wr64), .illegal(il64));

   bundle_t a32, a64;
   always_comb begin
      a32 = '0;
      a32.valid = v32; a32.pc = {32'b0, pc32}; a32.opcode = op32; a32.rd = rd32;
      a32.funct3 = f3_32; a32.rs1 = rs1_32; a32.rs2 = rs2_32; a32.funct7 = f7_32;
      a32.fmt = fmt32; a32.imm = {32'b0, imm32}; a32.u1 = u1_32; a32.u2 = u2_32;
      a32.wr = wr32; a32.ill = il32;
   end
   always_comb begin
      a64 = '0;
      a64.valid = v64; a64.pc = pc64; a64.opcode = op64; a64.rd = rd64;
      a64.funct3 = f3_64; a64.rs1 = rs1_64; a64.rs2 = rs2_64; a64.funct7 = f7_64;
      a64.fmt = fmt64; a64.imm = imm64; a64.u1 = u1_64; a64.u2 = u2_64;
      a64.wr = wr64; a64.ill = il64;
   end

   int      n_checks = 0;
   int      n_fail   = 0;
   bit      e_valid  = 1'b0;
   bit      known    = 1'b0;
   bit      armed    = 1'b0;
   bundle_t e32, e64;
   vec_t    tbl [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference decode built from the ISA rules: format/usage by opcode class, immediate as a signed sum.
   function automatic bundle_t model(input logic [31:0] i, input logic [63:0] pc, input bit x64, input bit es);
      bundle_t b;
      bit      uses_rd;
      longint  v;
      b = '0; uses_rd = 0; v = 0;
      b.valid = 1'b1;
      b.pc = x64 ? pc : {32'b0, pc[31:0]};
      b.opcode = i[6:0]; b.rd = i[11:7]; b.funct3 = i[14:12];
      b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.funct7 = i[31:25];
      b.fmt = 3'd7;
      if (i[1:0] != 2'b11) b.ill = 1'b1;
      else begin
         case (i[6:0])
            7'h33:        begin b.fmt = 3'd0; b.u1 = 1; b.u2 = 1; uses_rd = 1; end
            7'h13, 7'h03, 7'h67: begin b.fmt = 3'd1; b.u1 = 1; uses_rd = 1; end
            7'h23:        begin b.fmt = 3'd2; b.u1 = 1; b.u2 = 1; end
            7'h63:        begin b.fmt = 3'd3; b.u1 = 1; b.u2 = 1; end
            7'h37, 7'h17: begin b.fmt = 3'd4; uses_rd = 1; end
            7'h6F:        begin b.fmt = 3'd5; uses_rd = 1; end
            7'h0F, 7'h73: if (es) begin b.fmt = 3'd1; b.u1 = 1; uses_rd = 1; end else b.ill = 1;
            7'h1B:        if (x64) begin b.fmt = 3'd1; b.u1 = 1; uses_rd = 1; end else b.ill = 1;
            7'h3B:        if (x64) begin b.fmt = 3'd0; b.u1 = 1; b.u2 = 1; uses_rd = 1; end else b.ill = 1;
            default:      b.ill = 1;
         endcase
      end
      case (b.fmt)
         3'd1: v = (i[31] ? -longint'(2048) : 0) + longint'(i[30:20]);
         3'd2: v = (i[31] ? -longint'(2048) : 0) + longint'(i[30:25]) * 32 + longint'(i[11:7]);
         3'd3: v = (i[31] ? -longint'(4096) : 0) + longint'(i[7]) * 2048
                   + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
         3'd4: v = (i[31] ? -(longint'(1) << 31) : 0) + longint'(i[30:12]) * 4096;
         3'd5: v = (i[31] ? -(longint'(1) << 20) : 0) + longint'(i[19:12]) * 4096
                   + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
         default: v = 0;
      endcase
      if (b.ill) begin
         b.fmt = 3'd7; b.u1 = 0; b.u2 = 0; uses_rd = 0; v = 0;
      end
      b.wr  = uses_rd && (i[11:7] != 5'd0);
      b.imm = x64 ? 64'(v) : {32'b0, v[31:0]};
      return b;
   endfunction

   task automatic cmp_bundle(input string tag, input bundle_t act, input bundle_t exp, input bit data);
      chk({tag, " out_valid"}, act.valid, exp.valid);
      if (data) begin
         chk({tag, " out_pc"}, act.pc, exp.pc);
         chk({tag, " opcode"}, act.opcode, exp.opcode);
         chk({tag, " rd"}, act.rd, exp.rd);
         chk({tag, " funct3"}, act.funct3, exp.funct3);
         chk({tag, " rs1"}, act.rs1, exp.rs1);
         chk({tag, " rs2"}, act.rs2, exp.rs2);
         chk({tag, " funct7"}, act.funct7, exp.funct7);
         chk({tag, " fmt"}, act.fmt, exp.fmt);
         chk({tag, " imm"}, act.imm, exp.imm);
         chk({tag, " uses_rs1"}, act.u1, exp.u1);
         chk({tag, " uses_rs2"}, act.u2, exp.u2);
         chk({tag, " writes_rd"}, act.wr, exp.wr);
         chk({tag, " illegal"}, act.ill, exp.ill);
      end
   endtask

   // One clock: check in_ready before the edge, advance the model on the edge, check outputs on the falling edge.
   task automatic tick();
      bundle_t x;
      #1;
      if (armed) begin
         chk("in_ready32", r32, !e_valid || out_ready);
         chk("in_ready64", r64, !e_valid || out_ready);
      end
      @(posedge clk);
      if (rst) begin
         e_valid = 0; e32 = '0; e64 = '0; known = 1;
      end else if (flush) begin
         e_valid = 0; known = 0;
      end else if (in_valid && (!e_valid || out_ready)) begin
         e_valid = 1; known = 1;
         e32 = model(in_instr, in_pc, 1'b0, 1'b1);
         e64 = model(in_instr, in_pc, 1'b1, 1'b0);
      end else if (e_valid && out_ready) begin
         e_valid = 0; known = 0;
      end
      armed = 1;
      @(negedge clk);
      x = e32; x.valid = e_valid;
      cmp_bundle("dut32", a32, x, e_valid || known);
      x = e64; x.valid = e_valid;
      cmp_bundle("dut64", a64, x, e_valid || known);
   endtask

   task automatic drive(input bit v, input logic [31:0] instr, input logic [63:0] pc, input bit ordy, input bit fl);
      in_valid = v; in_instr = instr; in_pc = pc; out_ready = ordy; flush = fl;
   endtask

   initial begin
      tbl[0] = '{32'hFFF10093, 32'h100, 3'd1, 32'hFFFFFFFF, 5'd1,  5'd2, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      tbl[1] = '{32'h00512423, 32'h104, 3'd2, 32'h00000008, 5'd8,  5'd2, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 64'h8, 1'b0};
      tbl[2] = '{32'hFE000EE3, 32'h108, 3'd3, 32'hFFFFFFFC, 5'd29, 5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      tbl[3] = '{32'h123451B7, 32'h10C, 3'd4, 32'h12345000, 5'd3,  5'd8, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 64'h12345000, 1'b0};
      tbl[4] = '{32'h001000EF, 32'h110, 3'd5, 32'h00000800, 5'd1,  5'd0, 5'd1,  1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 64'h800, 1'b0};
      tbl[5] = '{32'h00000013, 32'h114, 3'd1, 32'h00000000, 5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 64'h0, 1'b0};
      tbl[6] = '{32'h00000000, 32'h118, 3'd7, 32'h00000000, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 64'h0, 1'b1};
      tbl[7] = '{32'hFFF1009B, 32'h11C, 3'd7, 32'h00000000, 5'd1,  5'd2, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      tbl[8] = '{32'h0000000F, 32'h120, 3'd1, 32'h00000000, 5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 64'h0, 1'b1};
      tbl[9] = '{32'h80000037, 32'h124, 3'd4, 32'h80000000, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 64'hFFFFFFFF80000000, 1'b0};

      // reset for two cycles with a valid word offered
      rst = 1'b1;
      drive(1'b1, 32'hFFF10093, 64'h100, 1'b1, 1'b0);
      tick();
      tick();
      chk("reset in_ready", r32, 1'b1);
      rst = 1'b0;

      foreach (tbl[k]) begin
         drive(1'b1, tbl[k].instr, {32'b0, tbl[k].pc}, 1'b1, 1'b0);
         tick();
         $display("vector %0d instr=%08h fmt=%0d imm=%08h illegal=%0d", k, tbl[k].instr, fmt32, imm32, il32);
         chk("tbl out_valid", v32, 1'b1);
         chk("tbl out_pc", pc32, tbl[k].pc);
         chk("tbl fmt", fmt32, tbl[k].fmt);
         chk("tbl imm", imm32, tbl[k].imm);
         chk("tbl rd", rd32, tbl[k].rd);
         chk("tbl rs1", rs1_32, tbl[k].rs1);
         chk("tbl rs2", rs2_32, tbl[k].rs2);
         chk("tbl uses_rs1", u1_32, tbl[k].u1);
         chk("tbl uses_rs2", u2_32, tbl[k].u2);
         chk("tbl writes_rd", wr32, tbl[k].wr);
         chk("tbl illegal", il32, tbl[k].ill);
         chk("tbl fmt64", fmt64, tbl[k].fmt64);
         chk("tbl imm64", imm64, tbl[k].imm64);
         chk("tbl illegal64", il64, tbl[k].ill64);
      end

      // backpressure: A held for three cycles while B waits, then B follows with no bubble
      drive(1'b1, 32'h00A00093, 64'h200, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'h00B00113, 64'h204, 1'b0, 1'b0);
      for (int s = 0; s < 3; s++) begin
         tick();
         $display("stall cycle %0d out_pc=%0h in_ready=%0d", s, pc32, r32);
         chk("bp in_ready", r32, 1'b0);
         chk("bp hold pc", pc32, 32'h200);
         chk("bp hold rd", rd32, 5'd1);
      end
      out_ready = 1'b1;
      tick();
      chk("bp B valid", v32, 1'b1);
      chk("bp B pc", pc32, 32'h204);
      chk("bp B rd", rd32, 5'd2);
      in_valid = 1'b0;
      tick();
      chk("bp drain", v32, 1'b0);

      // flush with downstream ready, then flush during a stall
      for (int m = 0; m < 2; m++) begin
         drive(1'b1, 32'h00A00093, 64'h300, 1'b1, 1'b0);
         tick();
         drive(1'b1, 32'h00C00193, 64'h304, (m == 0), 1'b1);
         tick();
         $display("flush case %0d out_valid=%0d", m, v32);
         chk("flush valid", v32, 1'b0);
         drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
         tick();
         chk("flush word dropped", v32, 1'b0);
      end

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [31:0] r;
         logic [6:0]  opc;
         logic [6:0]  opcs [14];
         opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73, 7'h1B, 7'h3B, 7'h7F};
         r = $urandom();
         opc = ($urandom_range(0, 9) == 0) ? r[6:0] : opcs[$urandom_range(0, 13)];
         rst = ($urandom_range(0, 59) == 0);
         drive($urandom_range(0, 3) != 0, {r[31:7], opc}, {$urandom(), $urandom()},
               $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         tick();
         if (n % 40 == 0)
            $display("random %0d instr=%08h out_valid=%0d fmt=%0d", n, in_instr, v32, fmt32);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
